// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port: request record, port bundles and arbiter state.
package mem_port_arbiter_pkg;

  localparam logic [1:0] M_XRD = 2'd0;
  localparam logic [1:0] M_XWR = 2'd1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  fcn;
    logic [2:0]  typ;
  } MemoryRequest;

  typedef struct packed {
    logic         req_valid;
    MemoryRequest req;
  } MemoryOut;

  typedef struct packed {
    logic        req_ready;
    logic        res_valid;
    logic [31:0] res_data;
  } MemoryIn;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} ArbState;

  typedef enum logic {OWN_IMEM, OWN_DMEM} ArbOwner;

endpackage

// File: rtl/mem_port_grant.sv
// Winner selection for the memory port: dmem-first, with a streak limit so fetch is never starved.
module mem_port_grant #(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic imem_req_valid,
  input  logic imem_kill,
  input  logic dmem_req_valid,
  output logic grant_imem,
  output logic grant_dmem
);

  localparam logic [3:0] StreakMax = 4'(MAX_DSTREAK);

  logic [3:0] streak_q, streak_d;
  logic       imem_elig;
  logic       at_max;

  assign imem_elig  = imem_req_valid & ~imem_kill;
  assign at_max     = (streak_q == StreakMax);
  assign grant_imem = idle & imem_elig & (~dmem_req_valid | at_max);
  assign grant_dmem = idle & dmem_req_valid & (~imem_elig | ~at_max);

  // The streak counts dmem wins while fetch is asking, killed or not.
  always_comb begin
    streak_d = streak_q;
    if (grant_dmem) begin
      if (imem_req_valid) streak_d = at_max ? StreakMax : streak_q + 4'd1;
      else                streak_d = 4'd0;
    end else if (grant_imem) begin
      streak_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) streak_q <= 4'd0;
    else        streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data access, one transaction in flight at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         imem_req_valid,
  input  MemoryRequest imem_req,
  output logic         imem_req_ready,
  output logic         imem_res_valid,
  output logic [31:0]  imem_res_data,
  input  logic         imem_kill,
  input  logic         dmem_req_valid,
  input  MemoryRequest dmem_req,
  output logic         dmem_req_ready,
  output logic         dmem_res_valid,
  output logic [31:0]  dmem_res_data,
  output logic         mem_req_valid,
  output MemoryRequest mem_req,
  input  logic         mem_req_ready,
  input  logic         mem_res_valid,
  input  logic [31:0]  mem_res_data,
  output logic         busy
);

  ArbState      state_q;
  ArbOwner      owner_q;
  logic         killed_q;
  MemoryRequest mem_req_q;
  logic         grant_imem, grant_dmem;
  logic         idle;
  logic         wait_res;

  // Gating with rst_n keeps the readies low while reset is held.
  assign idle = (state_q == ARB_IDLE) & rst_n;

  mem_port_grant #(
    .MAX_DSTREAK(MAX_DSTREAK)
  ) u_grant (
    .clk           (clk),
    .rst_n         (rst_n),
    .idle          (idle),
    .imem_req_valid(imem_req_valid),
    .imem_kill     (imem_kill),
    .dmem_req_valid(dmem_req_valid),
    .grant_imem    (grant_imem),
    .grant_dmem    (grant_dmem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_IMEM;
      killed_q  <= 1'b0;
      mem_req_q <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (grant_dmem) begin
            mem_req_q <= dmem_req;
            owner_q   <= OWN_DMEM;
            killed_q  <= 1'b0;
            state_q   <= ARB_ISSUE;
          end else if (grant_imem) begin
            mem_req_q <= imem_req;
            owner_q   <= OWN_IMEM;
            killed_q  <= 1'b0;
            state_q   <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (imem_kill && owner_q == OWN_IMEM) killed_q <= 1'b1;
          if (mem_req_ready) state_q <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (imem_kill && owner_q == OWN_IMEM) killed_q <= 1'b1;
          if (mem_res_valid) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign wait_res       = (state_q == ARB_WAIT) & mem_res_valid;
  assign imem_req_ready = grant_imem;
  assign dmem_req_ready = grant_dmem;
  // A kill arriving with the response itself must still suppress it.
  assign imem_res_valid = wait_res & (owner_q == OWN_IMEM) & ~killed_q & ~imem_kill;
  assign dmem_res_valid = wait_res & (owner_q == OWN_DMEM);
  assign imem_res_data  = mem_res_data;
  assign dmem_res_data  = mem_res_data;
  assign mem_req_valid  = (state_q == ARB_ISSUE);
  assign mem_req        = mem_req_q;
  assign busy           = (state_q != ARB_IDLE);

endmodule
